charlieplex_pwm_scheduler: RTL and testbench



---
 rtl/charlieplex_pkg.sv | 41 ++++
 rtl/charlieplex_pwm_slot.sv | 91 +++++++++
 rtl/charlieplex_pwm_scheduler.sv | 109 ++++++++++
 tb/tb_charlieplex_pwm_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplex PWM scheduler.
// Optional feature macro: CHARLIEPLEX_SKIP_DARK_EN (dark pixels get a 1-cycle slot).
package charlieplex_pkg;

    // Slot phase: dead-time blanking, then the PWM on-window.
    typedef enum logic [0:0] {
        StBlank = 1'b0,
        StOn    = 1'b1
    } slot_state_e;

    // Index width wide enough to hold PIXELCOUNT itself (used for range checks).
    function automatic int unsigned index_bits(input int unsigned pixelcount);
        return $clog2(pixelcount + 1);
    endfunction

    // On-window length in cycles for a given brightness width.
    function automatic int unsigned window_len(input int unsigned pwmbits);
        return (1 << pwmbits) - 1;
    endfunction

    // Counter width covering both the blanking and the on-window phases.
    function automatic int unsigned cnt_bits(input int unsigned deadtime,
                                             input int unsigned w);
        int unsigned m;
        m = (deadtime > w) ? deadtime : w;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Number of cycles a pixel occupies, given its sampled brightness.
    function automatic int unsigned slot_len(input int unsigned deadtime,
                                             input int unsigned pwmbits,
                                             input int unsigned brightness);
`ifdef CHARLIEPLEX_SKIP_DARK_EN
        if (brightness == 0) begin
            return 1;
        end
`endif
        return deadtime + window_len(pwmbits) + (brightness * 0);
    endfunction

endpackage

// File: rtl/charlieplex_pwm_slot.sv
// Per-slot sequencer: dead-time blanking followed by the PWM on-window.
// The state register runs one cycle ahead of the registered led_on output, so
// 'entry' flags that the next displayed cycle is the first of a new slot.
// Optional feature macro: CHARLIEPLEX_SKIP_DARK_EN.
module charlieplex_pwm_slot
    import charlieplex_pkg::*;
#(
    parameter int unsigned PWMBITS  = 4,
    parameter int unsigned DEADTIME = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PWMBITS-1:0] brightness,
    output logic               entry,
    output logic               slot_done,
    output logic               led_on
);

    localparam int unsigned W       = window_len(PWMBITS);
    localparam int unsigned CNTBITS = cnt_bits(DEADTIME, W);

    slot_state_e        state_q, state_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic [PWMBITS-1:0] level_q, level_d;
    logic               led_on_q, led_on_d;

    // State, slot brightness and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StBlank;
            cnt_q    <= '0;
            level_q  <= '0;
            led_on_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            led_on_q <= led_on_d;
        end
    end

    // Next-state logic, slot brightness capture and PWM comparator.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        slot_done = 1'b0;
        entry     = (state_q == StBlank) && (cnt_q == '0);

        // Brightness is captured once per slot; later changes cannot leak in.
        if (entry) begin
            level_d = brightness;
        end

        unique case (state_q)
            StBlank: begin
`ifdef CHARLIEPLEX_SKIP_DARK_EN
                if (entry && (brightness == '0)) begin
                    slot_done = 1'b1;
                    cnt_d     = '0;
                end else
`endif
                if (cnt_q == CNTBITS'(DEADTIME - 1)) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTBITS'(1);
                end
            end
            StOn: begin
                if (cnt_q == CNTBITS'(W - 1)) begin
                    slot_done = 1'b1;
                    state_d   = StBlank;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNTBITS'(1);
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase

        led_on_d = enable && (state_q == StOn) && (cnt_q < CNTBITS'(level_q));
    end

    assign led_on = led_on_q;

endmodule

// File: rtl/charlieplex_pwm_scheduler.sv
// Grayscale refresh controller for a charlieplexed LED array.
// Double-buffered brightness store, per-pixel time slots, frame-boundary swap.
// Optional feature macro: CHARLIEPLEX_SKIP_DARK_EN (handled in the slot sequencer).
module charlieplex_pwm_scheduler
    import charlieplex_pkg::*;
#(
    parameter int unsigned PIXELCOUNT = 12,
    parameter int unsigned PWMBITS    = 4,
    parameter int unsigned DEADTIME   = 2,
    localparam int unsigned INDEXBITS = index_bits(PIXELCOUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [INDEXBITS-1:0] wr_addr,
    input  logic [PWMBITS-1:0]   wr_data,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic [INDEXBITS-1:0] led_index,
    output logic                 led_on,
    output logic                 frame_start
);

    logic [PWMBITS-1:0]   mem [2][PIXELCOUNT];
    logic                 bank_q;
    logic [INDEXBITS-1:0] idx_q;
    logic [INDEXBITS-1:0] led_index_q;
    logic                 frame_start_q;
    logic                 swap_ack_q;

    logic                 entry;
    logic                 slot_done;
    logic                 wr_hit;
    logic                 swap_fire;
    logic [PWMBITS-1:0]   bright_sample;

    // Write qualification, swap decision and front-brightness sample with bypass.
    always_comb begin
        wr_hit    = wr_en && (wr_addr < INDEXBITS'(PIXELCOUNT));
        swap_fire = entry && (idx_q == '0) && swap_req;
        // On a swap edge the old back bank (plus any same-cycle write) becomes front.
        if (swap_fire) begin
            if (wr_hit && (wr_addr == idx_q)) begin
                bright_sample = wr_data;
            end else begin
                bright_sample = mem[~bank_q][idx_q];
            end
        end else begin
            bright_sample = mem[bank_q][idx_q];
        end
    end

    // Brightness store: host writes always land in the current back bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < int'(PIXELCOUNT); p++) begin
                    mem[b][p] <= '0;
                end
            end
        end else if (wr_hit) begin
            mem[~bank_q][wr_addr] <= wr_data;
        end
    end

    // Bank select, pixel walk and registered index/frame/swap outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q        <= 1'b0;
            idx_q         <= '0;
            led_index_q   <= '0;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
        end else begin
            if (swap_fire) begin
                bank_q <= ~bank_q;
            end
            if (slot_done) begin
                if (idx_q == INDEXBITS'(PIXELCOUNT - 1)) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + INDEXBITS'(1);
                end
            end
            led_index_q   <= idx_q;
            frame_start_q <= entry && (idx_q == '0);
            swap_ack_q    <= swap_fire;
        end
    end

    charlieplex_pwm_slot #(
        .PWMBITS  (PWMBITS),
        .DEADTIME (DEADTIME)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .brightness (bright_sample),
        .entry      (entry),
        .slot_done  (slot_done),
        .led_on     (led_on)
    );

    assign led_index   = led_index_q;
    assign frame_start = frame_start_q;
    assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_charlieplex_pwm_scheduler.sv
// Self-checking bench for charlieplex_pwm_scheduler with a frame-level reference model.
module tb_charlieplex_pwm_scheduler;

    localparam int NPIX = 12;
    localparam int PWMB = 4;
    localparam int DEAD = 2;
    localparam int WIN  = (1 << PWMB) - 1;
    localparam int IDXB = $clog2(NPIX + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic            wr_en = 1'b0;
    logic [IDXB-1:0] wr_addr = '0;
    logic [PWMB-1:0] wr_data = '0;
    logic            swap_req = 1'b0;
    logic            swap_ack;
    logic [IDXB-1:0] led_index;
    logic            led_on;
    logic            frame_start;

    charlieplex_pwm_scheduler #(
        .PIXELCOUNT (NPIX),
        .PWMBITS    (PWMB),
        .DEADTIME   (DEAD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .led_index   (led_index),
        .led_on      (led_on),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit on;
    } ent_t;

    // Reference model: visible and hidden brightness arrays plus the frame's
    // remaining (index, lit) schedule built from the visible array.
    int   front [NPIX];
    int   back  [NPIX];
    ent_t q [$];
    bit   started;
    int   cur_len, prev_len;
    int   exp_idx, exp_on, exp_fs, exp_ack;
    int   cyc, last_fs;
    bit   have_prev;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic build_frame();
        for (int p = 0; p < NPIX; p++) begin
            int len;
            len = DEAD + WIN;
`ifdef CHARLIEPLEX_SKIP_DARK_EN
            if (front[p] == 0) len = 1;
`endif
            for (int c = 0; c < len; c++) begin
                ent_t e;
                e.idx = p;
                e.on  = (c >= DEAD) && ((c - DEAD) < front[p]);
                q.push_back(e);
            end
        end
    endtask

    // One clock: advance the model with the current inputs, then compare outputs.
    task automatic tick();
        if (rst) begin
            started = 0;
            q.delete();
            for (int p = 0; p < NPIX; p++) begin
                front[p] = 0;
                back[p]  = 0;
            end
            exp_idx = 0; exp_on = 0; exp_fs = 0; exp_ack = 0;
            have_prev = 0;
        end else begin
            bit boundary;
            ent_t e;
            boundary = !started || (q.size() == 0);
            if (wr_en && (int'(wr_addr) < NPIX)) back[wr_addr] = int'(wr_data);
            exp_fs = 0;
            exp_ack = 0;
            if (boundary) begin
                if (swap_req) begin
                    for (int p = 0; p < NPIX; p++) begin
                        int t;
                        t = front[p]; front[p] = back[p]; back[p] = t;
                    end
                    exp_ack = 1;
                end
                build_frame();
                exp_fs   = 1;
                started  = 1;
                prev_len = cur_len;
                cur_len  = q.size();
            end
            e = q.pop_front();
            exp_idx = e.idx;
            exp_on  = (e.on && enable) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("led_index", int'(led_index), exp_idx);
        chk("led_on", int'(led_on), exp_on);
        chk("frame_start", int'(frame_start), exp_fs);
        chk("swap_ack", int'(swap_ack), exp_ack);
        if (!rst && frame_start === 1'b1) begin
            if (have_prev) chk("frame_len", cyc - last_fs, prev_len);
            last_fs   = cyc;
            have_prev = 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = IDXB'(addr);
        wr_data = PWMB'(data);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic swap_until_ack();
        int guard;
        swap_req = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (swap_ack !== 1'b1 && guard < 400);
        chk("swap_ack_seen", int'(swap_ack === 1'b1), 1);
        swap_req = 1'b0;
    endtask

    initial begin
        cyc = 0; cur_len = 0; prev_len = 0; last_fs = 0; have_prev = 0; started = 0;

        // Reset held: all outputs quiet.
        run(3);
        rst = 1'b0;

        // Idle, dark buffers: two full frames.
        run(2 * NPIX * (DEAD + WIN) + 5);

        // Single pixel brightness through a swap.
        write(5, 7);
        swap_until_ack();
        run(NPIX * (DEAD + WIN));

        // Edge brightness values plus random fill, then swap.
        write(3, 15);
        write(4, 1);
        for (int i = 0; i < 6; i++) write($urandom_range(0, 15), $urandom_range(0, 15));
        swap_until_ack();
        run(NPIX * (DEAD + WIN));

        // Mid-frame back-buffer writes (including out-of-range) without swap.
        write(5, 0);
        write(12, 9);
        write(15, 3);
        run(NPIX * (DEAD + WIN));

        // Write coincident with the swap edge lands in the new front.
        begin
            int guard;
            guard = 0;
            while (q.size() != 0 && guard < 400) begin
                tick();
                guard++;
            end
            chk("boundary_found", int'(q.size()), 0);
            wr_en = 1'b1; wr_addr = IDXB'(0); wr_data = PWMB'(11); swap_req = 1'b1;
            tick();
            wr_en = 1'b0; swap_req = 1'b0;
        end
        run(NPIX * (DEAD + WIN));

        // Random enable toggling for a frame.
        for (int i = 0; i < NPIX * (DEAD + WIN); i++) begin
            enable = 1'($urandom_range(0, 1));
            tick();
        end
        enable = 1'b1;

        // Reset mid-frame: everything returns to dark, index 0.
        run($urandom_range(20, 150));
        rst = 1'b1;
        swap_req = 1'b1;
        run(2);
        swap_req = 1'b0;
        rst = 1'b0;
        run(NPIX * (DEAD + WIN) + 3);

        // Fully random traffic over several frames.
        for (int i = 0; i < 5 * NPIX * (DEAD + WIN); i++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = IDXB'($urandom_range(0, 15));
            wr_data  = PWMB'($urandom_range(0, 15));
            swap_req = ($urandom_range(0, 2) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            tick();
        end
        wr_en = 1'b0; swap_req = 1'b0; enable = 1'b1;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
